// File: rtl/max7219_chain_if.sv
// max7219_chain_if: bus of the MAX7219 chain driver; master = fabric side (drives value/brightness), slave = driver (drives serial pins and init_done)
interface max7219_chain_if #(
  parameter int DEVICES = 1,
  parameter int VALUE_WIDTH = 24
);
  logic [DEVICES*VALUE_WIDTH-1:0] value;
  logic [3:0] brightness;
  logic mosi;
  logic sclk;
  logic sel;
  logic init_done;
  modport master (output value, brightness, input mosi, sclk, sel, init_done);
  modport slave (input value, brightness, output mosi, sclk, sel, init_done);
endinterface

// File: rtl/max7219_chain.sv
// max7219_chain: MAX7219 daisy-chain driver, one signed decimal per device; ports clk, rst (async, active-high), bus (slave: value, brightness in; mosi, sclk, sel, init_done out)
module max7219_chain #(
  parameter int DEVICES = 1,
  parameter int VALUE_WIDTH = 24,
  parameter int DIVIDER = 22,
  parameter int DP_POS = 0,
  parameter bit BLANK_LEADING = 1,
  parameter logic [3:0] BRIGHTNESS = 4'h4
) (
  input logic clk,
  input logic rst,
  max7219_chain_if.slave bus
);
  localparam int VW = VALUE_WIDTH;
  localparam int NB = DEVICES * 16;
  localparam int CW = $clog2(2 * NB);
  localparam int DW = $clog2(DIVIDER + 2);
  localparam int BLANK_MIN = DP_POS > 1 ? DP_POS : 1;
  typedef enum logic [2:0] {IDLE, SELECT, SHIFT, TAIL, LATCH, GAP} ser_t;
  typedef enum logic [1:0] {INIT, SNAP, CONV, DIGIT} seq_t;
  ser_t ser_q, ser_d;
  seq_t seq_q, seq_d;
  logic [DW-1:0] div_q;
  logic [CW-1:0] bit_q;
  logic [NB-1:0] sr_q, sr_d;
  logic [2:0] step_q;
  logic [5:0] conv_q;
  logic [3:0] bri_sent_q;
  logic bri_frame_q, init_done_q;
  logic [VW-1:0] bin_q [DEVICES];
  logic [39:0] bcd_q [DEVICES];
  logic neg_q [DEVICES];
  logic tick, load, done, bri_pending;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [15:0] init_word(input logic [2:0] s);
    case (s)
      3'd0: return 16'h0900;
      3'd1: return {8'h0A, 4'h0, BRIGHTNESS};
      3'd2: return 16'h0B07;
      3'd3: return 16'h0C01;
      default: return 16'h0F00;
    endcase
  endfunction

  function automatic logic [7:0] digit_seg(input logic [39:0] bcd, input logic neg, input logic [2:0] idx);
    logic [39:0] up;
    logic dp;
    up = bcd >> (4 * idx);
    dp = int'(idx) + 1 == DP_POS;
    if (idx == 3'd7) return neg ? 8'h01 : 8'h00;
    if (|bcd[39:28]) return {dp, 7'h01};
    if (BLANK_LEADING && int'(idx) >= BLANK_MIN && up == 40'd0) return 8'h00;
    return {dp, seg7(up[3:0])};
  endfunction

  function automatic logic [VW-1:0] magnitude(input logic [VW-1:0] v);
    return v[VW-1] ? VW'(-{v[VW-1], v}) : v;
  endfunction

  function automatic logic [39:0] dabble(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) r[4*i +: 4] = r[4*i +: 4] > 4'd4 ? r[4*i +: 4] + 4'd3 : r[4*i +: 4];
    return r;
  endfunction

  assign tick = div_q == '0;
  assign load = tick && (seq_q == INIT || seq_q == DIGIT) && (ser_q == IDLE || ser_q == GAP);
  assign done = tick && ser_q == LATCH;
  assign bri_pending = seq_q == DIGIT && bus.brightness != bri_sent_q;
  assign bus.sel = !(ser_q == SELECT || ser_q == SHIFT || ser_q == TAIL);
  assign bus.sclk = ser_q == SHIFT && bit_q[0];
  assign bus.mosi = ser_q == SHIFT && sr_q[NB-1];
  assign bus.init_done = init_done_q;

  always_comb begin
    ser_d = ser_q;
    if (tick)
      case (ser_q)
        IDLE, GAP: ser_d = load ? SELECT : IDLE;
        SELECT: ser_d = SHIFT;
        SHIFT: ser_d = bit_q == CW'(2 * NB - 1) ? TAIL : SHIFT;
        TAIL: ser_d = LATCH;
        LATCH: ser_d = GAP;
        default: ser_d = IDLE;
      endcase
  end

  always_comb begin
    seq_d = seq_q;
    case (seq_q)
      INIT: seq_d = done && step_q == 3'd4 ? SNAP : INIT;
      SNAP: seq_d = CONV;
      CONV: seq_d = conv_q == 6'(VW - 1) ? DIGIT : CONV;
      default: seq_d = done && !bri_frame_q && step_q == 3'd7 ? SNAP : DIGIT;
    endcase
  end

  always_comb begin
    sr_d = '0;
    for (int k = 0; k < DEVICES; k++)
      sr_d[k*16 +: 16] = seq_q == INIT ? init_word(step_q) :
                         bri_pending ? {8'h0A, 4'h0, bus.brightness} :
                         {{5'd0, step_q} + 8'd1, digit_seg(bcd_q[k], neg_q[k], step_q)};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ser_q <= IDLE;
      seq_q <= INIT;
      div_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      step_q <= '0;
      conv_q <= '0;
      bri_sent_q <= BRIGHTNESS;
      bri_frame_q <= 1'b0;
      init_done_q <= 1'b0;
      for (int k = 0; k < DEVICES; k++) begin
        bin_q[k] <= '0;
        bcd_q[k] <= '0;
        neg_q[k] <= 1'b0;
      end
    end else begin
      ser_q <= ser_d;
      seq_q <= seq_d;
      div_q <= tick ? DW'(DIVIDER) : div_q - 1'b1;
      if (load) begin
        sr_q <= sr_d;
        bit_q <= '0;
        bri_frame_q <= bri_pending;
      end else if (tick && ser_q == SHIFT) begin
        bit_q <= bit_q + 1'b1;
        if (bit_q[0]) sr_q <= sr_q << 1;
      end
      if (load && bri_pending) bri_sent_q <= bus.brightness;
      if (done && seq_q == INIT) begin
        step_q <= step_q == 3'd4 ? 3'd0 : step_q + 3'd1;
        init_done_q <= init_done_q | (step_q == 3'd4);
      end
      if (done && seq_q == DIGIT && !bri_frame_q) step_q <= step_q + 3'd1;
      conv_q <= seq_q == CONV ? conv_q + 6'd1 : 6'd0;
      for (int k = 0; k < DEVICES; k++)
        if (seq_q == SNAP) begin
          neg_q[k] <= bus.value[k*VW + VW - 1];
          bin_q[k] <= magnitude(bus.value[k*VW +: VW]);
          bcd_q[k] <= '0;
        end else if (seq_q == CONV) begin
          bcd_q[k] <= (dabble(bcd_q[k]) << 1) | {39'd0, bin_q[k][VW-1]};
          bin_q[k] <= bin_q[k] << 1;
        end
    end
endmodule

// File: tb/tb_max7219_chain.sv
// tb_max7219_chain: directed checks of the MAX7219 chain driver by decoding frames from the serial pins
module tb_max7219_chain;
  typedef struct {logic [47:0] w; int n; int low;} frame_t;
  logic clk = 1'b0, rst = 1'b1, rst_b = 1'b1;
  int checks = 0, failures = 0, bad_a = 0, bad_b = 0;
  frame_t qa[$], qb[$];
  logic [47:0] sha = '0, shb = '0;
  int na = 0, nb = 0, lowa = 0, lowb = 0;
  logic psa = 1'b1, pca = 1'b0, pma = 1'b0, psb = 1'b1, pcb = 1'b0, pmb = 1'b0;
  logic [15:0] init_w [5] = '{16'h0900, 16'h0A04, 16'h0B07, 16'h0C01, 16'h0F00};
  logic [15:0] pass_a1 [9] = '{16'h0133, 16'h02F9, 16'h036D, 16'h0A09, 16'h0430, 16'h0500, 16'h0600, 16'h0700, 16'h0801};
  logic [15:0] pass_a2 [8] = '{16'h017F, 16'h02FE, 16'h035F, 16'h047F, 16'h057F, 16'h0679, 16'h077F, 16'h0801};
  frame_t f;
  logic [15:0] e2, e1, e0;

  always #5 clk = ~clk;

  max7219_chain_if #(.DEVICES(1), .VALUE_WIDTH(24)) ba();
  max7219_chain_if #(.DEVICES(3), .VALUE_WIDTH(32)) bb();

  max7219_chain #(.DEVICES(1), .VALUE_WIDTH(24), .DIVIDER(1), .DP_POS(2), .BLANK_LEADING(1), .BRIGHTNESS(4'h4))
    dut_a (.clk(clk), .rst(rst), .bus(ba));
  max7219_chain #(.DEVICES(3), .VALUE_WIDTH(32), .DIVIDER(1), .DP_POS(0), .BLANK_LEADING(1), .BRIGHTNESS(4'h4))
    dut_b (.clk(clk), .rst(rst_b), .bus(bb));

  always @(negedge clk)
    if (rst) begin
      na = 0; lowa = 0; psa = 1'b1; pca = 1'b0; pma = 1'b0;
    end else begin
      if (!ba.sel) lowa++;
      if (ba.sclk && !pca) begin sha = {sha[46:0], ba.mosi}; na++; end
      if (pca && ba.sclk && ba.mosi != pma) bad_a++;
      if (ba.sel != psa && (pca || ba.sclk)) bad_a++;
      if (ba.sel && !psa) begin qa.push_back('{sha, na, lowa}); na = 0; lowa = 0; end
      psa = ba.sel; pca = ba.sclk; pma = ba.mosi;
    end

  always @(negedge clk)
    if (rst_b) begin
      nb = 0; lowb = 0; psb = 1'b1; pcb = 1'b0; pmb = 1'b0;
    end else begin
      if (!bb.sel) lowb++;
      if (bb.sclk && !pcb) begin shb = {shb[46:0], bb.mosi}; nb++; end
      if (pcb && bb.sclk && bb.mosi != pmb) bad_b++;
      if (bb.sel != psb && (pcb || bb.sclk)) bad_b++;
      if (bb.sel && !psb) begin qb.push_back('{shb, nb, lowb}); nb = 0; lowb = 0; end
      psb = bb.sel; pcb = bb.sclk; pmb = bb.mosi;
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic get(input bit b, output frame_t fr);
    int t;
    t = 0;
    while ((b ? qb.size() : qa.size()) == 0 && t < 3000) begin @(negedge clk); t++; end
    fr = '{48'h0, 0, 0};
    checks++;
    assert ((b ? qb.size() : qa.size()) > 0) else begin
      failures++;
      $error("FAIL frame_timeout got=none exp=frame");
    end
    if (b && qb.size() > 0) fr = qb.pop_front();
    else if (!b && qa.size() > 0) fr = qa.pop_front();
  endtask

  task automatic expa(input string tag, input logic [15:0] w);
    frame_t fr;
    get(1'b0, fr);
    chk(tag, 64'(fr.w[15:0]), 64'(w));
  endtask

  task automatic expb(input string tag, input logic [47:0] w);
    frame_t fr;
    get(1'b1, fr);
    chk(tag, 64'(fr.w), 64'(w));
  endtask

  task automatic wait_a(input bit want_sclk);
    int t;
    t = 0;
    while ((want_sclk ? ba.sclk !== 1'b1 : ba.sel !== 1'b0) && t < 1000) begin @(negedge clk); t++; end
    checks++;
    assert (t < 1000) else begin
      failures++;
      $error("FAIL wait_a got=timeout exp=event");
    end
  endtask

  initial begin
    ba.value = -24'sd1234;
    ba.brightness = 4'h4;
    bb.value = {32'd3, 32'd2, 32'd1};
    bb.brightness = 4'h4;
    repeat (3) @(negedge clk);
    chk("a_rst_sel", 64'(ba.sel), 64'd1);
    chk("a_rst_sclk", 64'(ba.sclk), 64'd0);
    chk("a_rst_mosi", 64'(ba.mosi), 64'd0);
    chk("a_rst_done", 64'(ba.init_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("a_first_fall", 64'(ba.sel), 64'd0);
    get(1'b0, f);
    chk("a_init_0", 64'(f.w[15:0]), 64'(init_w[0]));
    chk("a_bits", 64'(f.n), 64'd16);
    chk("a_sel_low", 64'(f.low), 64'd68);
    for (int i = 1; i < 5; i++) begin
      if (i == 4) chk("a_done_early", 64'(ba.init_done), 64'd0);
      expa($sformatf("a_init_%0d", i), init_w[i]);
    end
    repeat (4) @(negedge clk);
    chk("a_done", 64'(ba.init_done), 64'd1);
    for (int i = 0; i < 9; i++) begin
      if (i == 2) begin
        wait_a(1'b0);
        ba.brightness = 4'h9;
        ba.value = 24'h800000;
      end
      expa($sformatf("a_pass1_%0d", i), pass_a1[i]);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        wait_a(1'b0);
        ba.brightness = 4'h4;
        repeat (10) @(negedge clk);
        ba.brightness = 4'h9;
      end
      expa($sformatf("a_pass2_%0d", i), pass_a2[i]);
    end
    rst_b = 1'b0;
    get(1'b1, f);
    chk("b_init_0", 64'(f.w), 64'({3{init_w[0]}}));
    chk("b_bits", 64'(f.n), 64'd48);
    chk("b_sel_low", 64'(f.low), 64'd196);
    for (int i = 1; i < 5; i++) expb($sformatf("b_init_%0d", i), {3{init_w[i]}});
    expb("b_pass1_1", 48'h0179_016D_0130);
    expb("b_pass1_2", 48'h0200_0200_0200);
    expb("b_pass1_3", 48'h0300_0300_0300);
    bb.value = {32'd12345678, 32'hFFFF_FFFB, 32'd1};
    for (int d = 4; d <= 8; d++) expb($sformatf("b_pass1_%0d", d), {3{8'(d), 8'h00}});
    for (int d = 1; d <= 8; d++) begin
      e2 = {8'(d), d < 8 ? 8'h01 : 8'h00};
      e1 = {8'(d), d == 1 ? 8'h5B : d == 8 ? 8'h01 : 8'h00};
      e0 = {8'(d), d == 1 ? 8'h30 : 8'h00};
      expb($sformatf("b_pass2_%0d", d), {e2, e1, e0});
    end
    wait_a(1'b1);
    #1 rst = 1'b1;
    #1;
    chk("a_mid_rst_sel", 64'(ba.sel), 64'd1);
    chk("a_mid_rst_sclk", 64'(ba.sclk), 64'd0);
    chk("a_mid_rst_done", 64'(ba.init_done), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    qa.delete();
    expa("a_mid_rst_first", 16'h0900);
    chk("a_pin_order", 64'(bad_a), 64'd0);
    chk("b_pin_order", 64'(bad_b), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
